scs8hd_clkdlyline_prog: RTL and testbench
=========================================

Name: scs8hd_clkdlyline_prog

Overview:
- Parametrised, multi-channel, runtime-programmable clocked delay line; successor to the fixed single-input clock-delay buffer cells.
- Each of WIDTH channels delays its input by 0..DEPTH CLK cycles, selected at run time through a load handshake.
- A tap change holds the outputs glitch-free until the new tap holds valid data.
- Used for clock-domain skew trimming and strobe alignment in scs8hd-based macros.

Parameters:
- WIDTH, 4, number of independent channels sharing one tap setting.
- DEPTH, 16, maximum delay in CLK cycles; legal range 1..64.
- RST_SEL, 4, delay selected out of reset; legal range 1..DEPTH.
- SELW, clog2(DEPTH+1), derived localparam; not overridable.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- A  input  WIDTH  channel data inputs.
- SEL  input  SELW  requested delay in cycles.
- SEL_LD  input  1  load strobe, one cycle; sampled with SEL.
- X  output  WIDTH  delayed channel outputs.
- BUSY  output  1  high while a tap change is settling; loads are ignored.
- ERR  output  1  present only with CLKDLYLINE_ERR_EN.

Behaviour:
- Interface: one clock, CLK; reset RESET is synchronous and active-high.
- Storage: per channel, a shift chain stage[1..DEPTH]. Each cycle stage[1]<=A and stage[k]<=stage[k-1]. The chain shifts in every state, including BUSY.
- Tap: tap[0]=A (combinational bypass); tap[k]=stage[k].
- Registers: active_sel (SELW bits), hold_q (WIDTH bits), settle counter cnt (SELW bits).
- Reset, when RESET is high at a rising edge:
  - all stages 0; hold_q=0; active_sel=RST_SEL; cnt=0; state=RUN.
  - After that edge: X=0, BUSY=0.
  - RESET has priority over a simultaneous SEL_LD. Reset mid-FLUSH aborts the change.
- State machine, two states:
  - RUN: X=tap[active_sel]; hold_q<=X each cycle; BUSY=0.
  - FLUSH: X=hold_q, frozen; BUSY=1; cnt decrements each cycle; FLUSH->RUN when cnt==1 at an edge.
- Load handling:
  - In RUN with SEL_LD=1: clamp SEL to DEPTH if SEL>DEPTH, then active_sel<=clamped value.
  - If the clamped value differs from active_sel and is nonzero: cnt<=clamped value, state<=FLUSH.
  - If the clamped value is 0: bypass takes effect next cycle with no FLUSH, since tap[0] is always valid.
  - If the clamped value equals active_sel: no state change, BUSY stays 0.
- Latency:
  - In RUN with active_sel=N≥1, X at cycle t equals A at cycle t−N. With N=0, X follows A in the same cycle.
  - After a load to N≥1, BUSY is high for exactly N cycles. The first unfrozen X equals A sampled N cycles earlier.
- Ignored loads: SEL_LD while BUSY=1 is ignored, and active_sel and cnt are unchanged.
- Channels are fully independent in data, with a shared tap.
- No X/Z propagation requirements beyond standard RTL semantics.

Optional Feature:
- Macro: CLKDLYLINE_ERR_EN.
- Defined:
  - ERR port exists.
  - ERR pulses high for one cycle, the cycle after an edge where SEL_LD=1 and either BUSY=1 or SEL>DEPTH.
  - Clamping and ignore behaviour are unchanged.
  - ERR reset value is 0.
- Undefined: ERR port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset delay: WIDTH=4, DEPTH=16, RST_SEL=4. Hold RESET 2 cycles, then drive A=1,2,3,... per cycle. X=0 for 4 cycles, then X=1,2,3,...; BUSY=0 throughout.
- Increase delay: in RUN at delay 4, pulse SEL_LD with SEL=9.
  - BUSY=1 for exactly 9 cycles, with X frozen at the last pre-load value.
  - Then X equals A delayed by 9 cycles.
- Bypass: in RUN at delay 9, pulse SEL_LD with SEL=0. Next cycle X==A combinationally and BUSY stays 0.
- Clamp and ignore:
  - SEL_LD with SEL=31 and DEPTH=16: delay becomes 16 and BUSY lasts 16 cycles.
  - SEL_LD with SEL=3 during that BUSY: ignored, delay remains 16.
  - With CLKDLYLINE_ERR_EN, ERR pulses once for each of the two loads.
- Reset mid-FLUSH: assert RESET at the 5th BUSY cycle of a load to 12.
  - Next cycle: BUSY=0, X=0, delay=RST_SEL=4.
  - RESET and SEL_LD in the same cycle leaves delay=4.
- Same-value load: SEL_LD with SEL equal to active_sel (4). No BUSY, and X continues uninterrupted with no freeze.

Source files
------------

// File: rtl/scs8hd_clkdlyline_prog.sv
// Multi-channel runtime-programmable clocked delay line with a glitch-free tap change.
// Define CLKDLYLINE_ERR_EN to add the ERR output that flags ignored or clamped loads.
module scs8hd_clkdlyline_prog #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 16,
  parameter int RST_SEL = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [WIDTH-1:0]                 A,
  input  logic [$clog2(DEPTH+1)-1:0]       SEL,
  input  logic                             SEL_LD,
  output logic [WIDTH-1:0]                 X,
  output logic                             BUSY
`ifdef CLKDLYLINE_ERR_EN
  ,
  output logic                             ERR
`endif
);

  localparam int SELW = $clog2(DEPTH + 1);
  localparam logic [SELW-1:0] DEPTH_S   = SELW'(DEPTH);
  localparam logic [SELW-1:0] RST_SEL_S = SELW'(RST_SEL);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [WIDTH-1:0] stage_q [1:DEPTH];
  logic [SELW-1:0]  active_sel_q, active_sel_d;
  logic [SELW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [0:0]       state_q, state_d;
  logic [SELW-1:0]  sel_clamped;
  logic [WIDTH-1:0] x_run;

  // NOTE: the chain is a real register array, so it is cleared explicitly; a
  // reset-less chain would leak stale pre-reset data to X after RESET.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 1; k <= DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[1] <= A;
      for (int k = 2; k <= DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  // Tap 0 is the combinational bypass; every other tap is a chain stage.
  always_comb begin
    x_run = A;
    for (int k = 1; k <= DEPTH; k++) begin
      if (active_sel_q == SELW'(k)) x_run = stage_q[k];
    end
  end

  assign sel_clamped = (SEL > DEPTH_S) ? DEPTH_S : SEL;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    if (state_q == ST_RUN) begin
      hold_d = x_run;
      if (SEL_LD) begin
        active_sel_d = sel_clamped;
        if (sel_clamped != active_sel_q && sel_clamped != '0) begin
          cnt_d   = sel_clamped;
          state_d = ST_FLUSH;
        end
      end
    end else begin
      // The new tap is fully populated once cnt reaches 1 at an edge.
      cnt_d = cnt_q - SELW'(1);
      if (cnt_q == SELW'(1)) state_d = ST_RUN;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      active_sel_q <= RST_SEL_S;
      cnt_q        <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
    end
  end

  assign BUSY = (state_q == ST_FLUSH);
  assign X    = BUSY ? hold_q : x_run;

`ifdef CLKDLYLINE_ERR_EN
  logic err_q;

  always_ff @(posedge CLK) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= SEL_LD && (BUSY || SEL > DEPTH_S);
  end

  assign ERR = err_q;
`endif

endmodule

// File: tb/tb_scs8hd_clkdlyline_prog.sv
// Directed bench for scs8hd_clkdlyline_prog: a behavioural model pushes expected
// outputs to a scoreboard queue each cycle and the sampled DUT outputs are popped against it.
module tb_scs8hd_clkdlyline_prog;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 16;
  localparam int RST_SEL = 4;
  localparam int SELW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [WIDTH-1:0] x;
    logic             busy;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [SELW-1:0]  sel = '0;
  logic             sel_ld = 1'b0;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             err;

  int tests = 0;
  int fails = 0;

  exp_t             sb [$];
  logic [WIDTH-1:0] past [$];
  int               m_delay = RST_SEL;
  int               m_busy = 0;
  logic [WIDTH-1:0] m_frozen = '0;
  logic             m_err = 1'b0;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] acnt = '0;

  always #5 clk = ~clk;

  scs8hd_clkdlyline_prog #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RST_SEL(RST_SEL)
  ) dut (
    .CLK   (clk),
    .RESET (reset),
    .A     (a),
    .SEL   (sel),
    .SEL_LD(sel_ld),
    .X     (x),
    .BUSY  (busy)
`ifdef CLKDLYLINE_ERR_EN
    ,
    .ERR   (err)
`endif
  );

`ifndef CLKDLYLINE_ERR_EN
  assign err = 1'b0;
`endif

  // One clock cycle: drive inputs, predict outputs, sample them mid-cycle, advance the model.
  task automatic step(input logic [WIDTH-1:0] av, input logic [SELW-1:0] sv,
                      input logic ld, input logic rst, input string tag);
    exp_t             e;
    exp_t             got;
    logic [WIDTH-1:0] cur_x;
    int               c;
    @(posedge clk);
    #1;
    a = av; sel = sv; sel_ld = ld; reset = rst;
    cur_x = '0;
    if (m_valid) begin
      cur_x  = (m_delay == 0) ? av : past[m_delay-1];
      e.x    = (m_busy > 0) ? m_frozen : cur_x;
      e.busy = (m_busy > 0);
      e.err  = m_err;
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      tests++;
      assert (x === got.x) else begin
        fails++;
        $error("FAIL %s X: observed %0h expected %0h at %0t", tag, x, got.x, $time);
      end
      tests++;
      assert (busy === got.busy) else begin
        fails++;
        $error("FAIL %s BUSY: observed %b expected %b at %0t", tag, busy, got.busy, $time);
      end
`ifdef CLKDLYLINE_ERR_EN
      tests++;
      assert (err === got.err) else begin
        fails++;
        $error("FAIL %s ERR: observed %b expected %b at %0t", tag, err, got.err, $time);
      end
`endif
    end
    if (rst) begin
      past.delete();
      for (int i = 0; i < DEPTH; i++) past.push_back('0);
      m_delay  = RST_SEL;
      m_busy   = 0;
      m_frozen = '0;
      m_err    = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      m_err = ld && (m_busy > 0 || int'(sv) > DEPTH);
      if (m_busy > 0) begin
        m_busy--;
      end else begin
        m_frozen = cur_x;
        if (ld) begin
          c = (int'(sv) > DEPTH) ? DEPTH : int'(sv);
          if (c != m_delay && c != 0) m_busy = c;
          m_delay = c;
        end
      end
      past.push_front(av);
      void'(past.pop_back());
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      acnt = acnt + 1'b1;
      step(acnt, '0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic load(input logic [SELW-1:0] sv, input string tag);
    acnt = acnt + 1'b1;
    step(acnt, sv, 1'b1, 1'b0, tag);
  endtask

  initial begin
    step('0, '0, 1'b0, 1'b1, "reset");
    step('0, '0, 1'b0, 1'b1, "reset");
    run(20, "rst_delay");

    load(5'd9, "load9");
    run(25, "delay9");

    load(5'd0, "load0");
    run(6, "bypass");

    load(5'd31, "load31");
    load(5'd3, "ignored3");
    run(22, "clamp16");

    load(5'd12, "load12");
    run(4, "flush12");
    acnt = acnt + 1'b1;
    step(acnt, 5'd12, 1'b1, 1'b1, "rst_mid_flush");
    run(10, "after_rst");

    load(5'd4, "same4");
    run(8, "same_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
